// File: rtl/mac_fifo_frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_fifo_frame_buffer_if
// Purpose  : MAC-side write stream and consumer-side pop bus of the frame FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface mac_fifo_frame_buffer_if #(
   parameter int DATA_IN_WIDTH  = 8,
   parameter int DATA_OUT_WIDTH = 32
);
   localparam int c_CW = $clog2(DATA_OUT_WIDTH / DATA_IN_WIDTH) + 1;

   logic [DATA_IN_WIDTH-1:0]  data_in;
   logic                      data_in_enable;
   logic                      data_in_start;
   logic                      data_in_end;
   logic                      error;
   logic [DATA_OUT_WIDTH-1:0] data_out;
   logic                      data_out_enable;
   logic                      data_out_start;
   logic                      data_out_end;
   logic                      data_out_valid;
   logic [c_CW-1:0]           data_out_count;
   logic                      retry;

   modport master (
      output data_in, data_in_enable, data_in_start, data_in_end, error,
             data_out_enable, retry,
      input  data_out, data_out_start, data_out_end, data_out_valid, data_out_count
   );

   modport slave (
      input  data_in, data_in_enable, data_in_start, data_in_end, error,
             data_out_enable, retry,
      output data_out, data_out_start, data_out_end, data_out_valid, data_out_count
   );
endinterface
`default_nettype wire

// File: rtl/mac_fifo_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mac_fifo_frame_buffer
// Purpose  : Store-and-forward frame FIFO packing MAC units into wide words,
//            with error/overflow discard and replay of the frame being read.
// Revision : 1.0 - initial release
// ============================================================================
module mac_fifo_frame_buffer #(
   parameter int DATA_IN_WIDTH  = 8,
   parameter int DATA_OUT_WIDTH = 32,
   parameter int FIFO_DEPTH     = 12
) (
   input wire logic               clock,
   input wire logic               reset,
   mac_fifo_frame_buffer_if.slave bus
);
   localparam int c_RATIO = DATA_OUT_WIDTH / DATA_IN_WIDTH;
   localparam int c_LW    = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
   localparam int c_CW    = $clog2(c_RATIO) + 1;
   localparam int c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   // Pointers run over 2*FIFO_DEPTH so that full and empty stay distinguishable.
   localparam int c_PW    = $clog2(2 * FIFO_DEPTH);

   function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
      return (p == c_PW'(2 * FIFO_DEPTH - 1)) ? '0 : p + c_PW'(1);
   endfunction

   function automatic logic [c_AW-1:0] ptr_addr(input logic [c_PW-1:0] p);
      return (p >= c_PW'(FIFO_DEPTH)) ? c_AW'(p - c_PW'(FIFO_DEPTH)) : c_AW'(p);
   endfunction

   function automatic logic [c_PW-1:0] ptr_dist(input logic [c_PW-1:0] a, input logic [c_PW-1:0] b);
      return (a >= b) ? a - b : a + c_PW'(2 * FIFO_DEPTH) - b;
   endfunction

   logic [DATA_OUT_WIDTH-1:0] r_mem_data  [FIFO_DEPTH];
   logic                      r_mem_start [FIFO_DEPTH];
   logic                      r_mem_end   [FIFO_DEPTH];
   logic [c_CW-1:0]           r_mem_count [FIFO_DEPTH];

   logic [c_PW-1:0]           r_wr_ptr, r_commit_ptr, r_rd_ptr, r_base_ptr;
   logic [DATA_OUT_WIDTH-1:0] r_pack;
   logic [c_LW-1:0]           r_lane;
   logic                      r_first;
   logic                      r_in_frame;

   logic [c_PW-1:0]           w_wr_base;
   logic [DATA_OUT_WIDTH-1:0] w_word;
   logic [c_LW-1:0]           w_lane;
   logic                      w_first, w_drop, w_accept, w_flush, w_full, w_write, w_overflow;
   logic                      w_retry, w_pop;
   logic [c_AW-1:0]           w_rd_addr;

   // A start unit always restarts from the commit point, discarding any open frame.
   always_comb begin
      w_wr_base  = bus.data_in_start ? r_commit_ptr : r_wr_ptr;
      w_lane     = bus.data_in_start ? '0 : r_lane;
      w_word     = bus.data_in_start ? '0 : r_pack;
      for (int i = 0; i < c_RATIO; i++) begin
         if (c_LW'(i) == w_lane) begin
            w_word[i*DATA_IN_WIDTH +: DATA_IN_WIDTH] = bus.data_in;
         end
      end
      w_first    = bus.data_in_start | r_first;
      w_drop     = r_in_frame & bus.error;
      w_accept   = ~w_drop & bus.data_in_enable & (bus.data_in_start | r_in_frame);
      w_flush    = w_accept & (bus.data_in_end | (w_lane == c_LW'(c_RATIO - 1)));
      w_full     = (ptr_dist(w_wr_base, r_base_ptr) == c_PW'(FIFO_DEPTH));
      w_write    = w_flush & ~w_full;
      w_overflow = w_flush & w_full;
      w_retry    = bus.retry & (r_rd_ptr != r_base_ptr);
      w_pop      = bus.data_out_enable & ~w_retry & (r_rd_ptr != r_commit_ptr);
      w_rd_addr  = ptr_addr(r_rd_ptr);
   end

   always_ff @(posedge clock) begin
      if (w_write) begin
         r_mem_data[ptr_addr(w_wr_base)]  <= w_word;
         r_mem_start[ptr_addr(w_wr_base)] <= w_first;
         r_mem_end[ptr_addr(w_wr_base)]   <= bus.data_in_end;
         r_mem_count[ptr_addr(w_wr_base)] <= c_CW'(w_lane) + c_CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_pack       <= '0;
         r_lane       <= '0;
         r_first      <= 1'b0;
         r_in_frame   <= 1'b0;
      end else if (w_drop || w_overflow) begin
         r_wr_ptr     <= r_commit_ptr;
         r_pack       <= '0;
         r_lane       <= '0;
         r_first      <= 1'b0;
         r_in_frame   <= 1'b0;
      end else if (w_accept) begin
         if (w_flush) begin
            r_wr_ptr   <= ptr_inc(w_wr_base);
            r_pack     <= '0;
            r_lane     <= '0;
            r_first    <= 1'b0;
            r_in_frame <= ~bus.data_in_end;
            if (bus.data_in_end) begin
               r_commit_ptr <= ptr_inc(w_wr_base);
            end
         end else begin
            r_wr_ptr   <= w_wr_base;
            r_pack     <= w_word;
            r_lane     <= w_lane + c_LW'(1);
            r_first    <= w_first;
            r_in_frame <= 1'b1;
         end
      end
   end

   // The base pointer pins the frame under read so retry can rewind and the writer cannot overrun it.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_ptr           <= '0;
         r_base_ptr         <= '0;
         bus.data_out       <= '0;
         bus.data_out_start <= 1'b0;
         bus.data_out_end   <= 1'b0;
         bus.data_out_count <= '0;
         bus.data_out_valid <= 1'b0;
      end else begin
         bus.data_out_valid <= w_pop;
         if (w_retry) begin
            r_rd_ptr <= r_base_ptr;
         end else if (w_pop) begin
            bus.data_out       <= r_mem_data[w_rd_addr];
            bus.data_out_start <= r_mem_start[w_rd_addr];
            bus.data_out_end   <= r_mem_end[w_rd_addr];
            bus.data_out_count <= r_mem_count[w_rd_addr];
            r_rd_ptr           <= ptr_inc(r_rd_ptr);
            if (r_mem_end[w_rd_addr]) begin
               r_base_ptr <= ptr_inc(r_rd_ptr);
            end else if (r_mem_start[w_rd_addr]) begin
               r_base_ptr <= r_rd_ptr;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mac_fifo_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_fifo_frame_buffer
// Purpose  : Directed and random stimulus against a frame-level queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_fifo_frame_buffer;
   localparam int c_IW    = 8;
   localparam int c_OW    = 32;
   localparam int c_DEPTH = 12;
   localparam int c_RATIO = 4;

   typedef struct packed {
      logic [31:0] data;
      logic        s;
      logic        e;
      logic [2:0]  cnt;
   } word_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mac_fifo_frame_buffer_if #(.DATA_IN_WIDTH(c_IW), .DATA_OUT_WIDTH(c_OW)) bus ();

   mac_fifo_frame_buffer #(
      .DATA_IN_WIDTH (c_IW),
      .DATA_OUT_WIDTH(c_OW),
      .FIFO_DEPTH    (c_DEPTH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   int n_total = 0;
   int n_bad   = 0;

   // Model: m_store holds every committed word from the start of the frame under read.
   word_t      m_store  [$];
   word_t      m_wframe [$];
   logic [7:0] m_bytes  [$];
   bit         m_in_frame;
   bit         m_first;
   int         m_rd_idx;
   word_t      m_out;
   bit         m_valid;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_store.delete();
      m_wframe.delete();
      m_bytes.delete();
      m_in_frame = 0;
      m_first    = 0;
      m_rd_idx   = 0;
      m_out      = '0;
      m_valid    = 0;
   endtask

   task automatic model_drop();
      m_wframe.delete();
      m_bytes.delete();
      m_in_frame = 0;
      m_first    = 0;
   endtask

   task automatic model_step(input bit en, input bit st, input bit ed, input bit er,
                             input logic [7:0] d, input bit pop, input bit rt);
      int    free_cnt;
      word_t w;
      free_cnt = 0;
      m_valid  = 0;
      if (rt && m_rd_idx > 0) begin
         m_rd_idx = 0;
      end else if (pop && m_rd_idx < m_store.size()) begin
         m_out   = m_store[m_rd_idx];
         m_valid = 1;
         m_rd_idx++;
         if (m_out.e) begin
            free_cnt = m_rd_idx;
            m_rd_idx = 0;
         end
      end
      if (m_in_frame && er) begin
         model_drop();
      end else if (en && (st || m_in_frame)) begin
         if (st) begin
            model_drop();
            m_in_frame = 1;
            m_first    = 1;
         end
         m_bytes.push_back(d);
         if (ed || m_bytes.size() == c_RATIO) begin
            if (m_store.size() + m_wframe.size() >= c_DEPTH) begin
               model_drop();
            end else begin
               w = '0;
               foreach (m_bytes[i]) w.data[i*8 +: 8] = m_bytes[i];
               w.cnt = 3'(m_bytes.size());
               w.s   = m_first;
               w.e   = ed;
               m_wframe.push_back(w);
               m_bytes.delete();
               m_first = 0;
               if (ed) begin
                  foreach (m_wframe[i]) m_store.push_back(m_wframe[i]);
                  m_wframe.delete();
                  m_in_frame = 0;
               end
            end
         end
      end
      for (int i = 0; i < free_cnt; i++) void'(m_store.pop_front());
   endtask

   function automatic logic [63:0] observed();
      return {26'd0, bus.data_out_valid, bus.data_out, bus.data_out_start,
              bus.data_out_end, bus.data_out_count};
   endfunction

   task automatic cyc(input bit en, input bit st, input bit ed, input bit er,
                      input logic [7:0] d, input bit pop, input bit rt, input string tag);
      bus.data_in         = d;
      bus.data_in_enable  = en;
      bus.data_in_start   = st;
      bus.data_in_end     = ed;
      bus.error           = er;
      bus.data_out_enable = pop;
      bus.retry           = rt;
      model_step(en, st, ed, er, d, pop, rt);
      @(posedge clock);
      #1;
      check_value(tag, observed(), {26'd0, m_valid, m_out});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.data_in_enable  = 0;
      bus.data_in_start   = 0;
      bus.data_in_end     = 0;
      bus.error           = 0;
      bus.data_out_enable = 0;
      bus.retry           = 0;
      bus.data_in         = '0;
      model_reset();
      @(posedge clock);
      #1;
      check_value("reset_outputs", observed(), 64'd0);
      reset = 1'b0;
   endtask

   task automatic push_frame(input int n, input logic [7:0] first_byte, input logic [7:0] step);
      for (int i = 0; i < n; i++)
         cyc(1, i == 0, i == n - 1, 0, first_byte + 8'(i) * step, 0, 0, "push");
   endtask

   task automatic pop_n(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00, 1, 0, tag);
   endtask

   initial begin
      do_reset();

      // 20-byte frame into five words
      push_frame(20, 8'h01, 8'h01);
      pop_n(1, "t1_pop");
      check_value("t1_first", {31'd0, bus.data_out_start, bus.data_out}, {31'd0, 1'b1, 32'h04030201});
      pop_n(4, "t1_pop");
      check_value("t1_last", {28'd0, bus.data_out_end, bus.data_out_count, bus.data_out},
                  {28'd0, 1'b1, 3'd4, 32'h14131211});

      // errored frame is dropped, following frame survives
      for (int i = 0; i < 4; i++) cyc(1, i == 0, 0, i == 3, 8'h11 * 8'(i + 1), 0, 0, "t2_err");
      push_frame(11, 8'h55, 8'h11);
      pop_n(1, "t2_pop");
      check_value("t2_first", {31'd0, bus.data_out_start, bus.data_out}, {31'd0, 1'b1, 32'h88776655});
      pop_n(2, "t2_pop");
      check_value("t2_end", {28'd0, bus.data_out_end, bus.data_out_count, bus.data_out},
                  {28'd0, 1'b1, 3'd3, 32'h00FFEEDD});
      pop_n(1, "t2_empty");
      check_value("t2_hold", {31'd0, bus.data_out_valid, bus.data_out}, {31'd0, 1'b0, 32'h00FFEEDD});

      // one-byte frame
      cyc(1, 1, 1, 0, 8'hA5, 0, 0, "t3_push");
      pop_n(1, "t3_pop");
      check_value("t3_word", {26'd0, bus.data_out_valid, bus.data_out, bus.data_out_start,
                  bus.data_out_end, bus.data_out_count}, {26'd0, 1'b1, 32'h000000A5, 1'b1, 1'b1, 3'd1});

      // 13-word frame overflows and is dropped
      push_frame(52, 8'h00, 8'h03);
      pop_n(1, "t4_empty");
      check_value("t4_dropped", {63'd0, bus.data_out_valid}, 64'd0);
      push_frame(4, 8'hC0, 8'h01);
      pop_n(1, "t4_pop");
      check_value("t4_after", {26'd0, bus.data_out_valid, bus.data_out, bus.data_out_start,
                  bus.data_out_end, bus.data_out_count}, {26'd0, 1'b1, 32'hC3C2C1C0, 1'b1, 1'b1, 3'd4});

      // retry replays from the start word; coinciding pop is suppressed
      push_frame(20, 8'h01, 8'h01);
      pop_n(2, "t5_pop");
      cyc(0, 0, 0, 0, 8'h00, 1, 1, "t5_retry");
      check_value("t5_retry_nopop", {63'd0, bus.data_out_valid}, 64'd0);
      pop_n(1, "t5_replay");
      check_value("t5_first", {31'd0, bus.data_out_start, bus.data_out}, {31'd0, 1'b1, 32'h04030201});
      pop_n(4, "t5_rest");
      check_value("t5_last", {28'd0, bus.data_out_end, bus.data_out_count, bus.data_out},
                  {28'd0, 1'b1, 3'd4, 32'h14131211});

      // reset mid-frame discards the partial frame
      for (int i = 0; i < 6; i++) cyc(1, i == 0, 0, 0, 8'h30 + 8'(i), 0, 0, "t6_partial");
      do_reset();
      pop_n(1, "t6_empty");
      push_frame(4, 8'hD0, 8'h01);
      pop_n(1, "t6_pop");
      check_value("t6_word", {28'd0, bus.data_out_end, bus.data_out_count, bus.data_out},
                  {28'd0, 1'b1, 3'd4, 32'hD3D2D1D0});

      // random traffic with concurrent writes, pops, errors and retries
      for (int n = 0; n < 4000; n++) begin
         bit en, st, ed, er, pop, rt;
         en  = ($urandom_range(99) < 70);
         st  = m_in_frame ? ($urandom_range(99) < 2) : ($urandom_range(99) < 25);
         ed  = ($urandom_range(99) < 12);
         er  = ($urandom_range(199) < 2);
         pop = ($urandom_range(99) < 45);
         rt  = ($urandom_range(99) < 3);
         cyc(en, st, ed, er, 8'($urandom), pop, rt, "random");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mac_fifo_frame_buffer.md
Name: mac_fifo_frame_buffer

Overview:
- Single-clock, store-and-forward frame FIFO between the MAC byte stream and a wider consumer.
- Packs DATA_IN_WIDTH input units into DATA_OUT_WIDTH words and marks frame start/end per word.
- Discards frames flagged as errored or overflowing.
- Supports retry (replay of the frame currently being read).

Parameters:
- DATA_IN_WIDTH, 8, input unit width.
- DATA_OUT_WIDTH, 32, output word width; must be an integer multiple of DATA_IN_WIDTH; RATIO = DATA_OUT_WIDTH/DATA_IN_WIDTH.
- FIFO_DEPTH, 12, storage depth in output words; any value ≥2, not restricted to powers of two.

Ports:
- clock  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  DATA_IN_WIDTH  input unit.
- data_in_enable  in  1  data_in valid this cycle.
- data_in_start  in  1  first unit of frame (qualified by enable).
- data_in_end  in  1  last unit of frame (qualified by enable).
- error  in  1  drop the frame currently being written.
- data_out  out  DATA_OUT_WIDTH  popped word.
- data_out_enable  in  1  pop request.
- data_out_start  out  1  popped word is first of frame.
- data_out_end  out  1  popped word is last of frame.
- data_out_valid  out  1  pulses one cycle when a pop succeeded.
- data_out_count  out  $clog2(RATIO)+1  valid units in popped word (RATIO except possibly on end word).
- retry  in  1  rewind read side to start of current frame.

Behaviour:
- Reset: all outputs 0, read/write/commit pointers 0, packer empty, not in-frame. Reset mid-frame discards the partial frame.
- Packing: first unit of a word goes to bits [DATA_IN_WIDTH-1:0], ascending lanes. A word is written when RATIO units are collected, or on an end unit. Unused lanes of a partial word are 0. Each word stores start, end and count flags.
- Write side: a unit with enable and start opens a frame. Enabled units outside a frame are ignored; an end outside a frame is ignored. start and end on the same unit form a one-word frame.
- start while already in-frame: the old frame is dropped, then the new frame opens.
- Commit: on the end unit the write pointer is copied to the commit pointer. The reader sees the frame from the next cycle (not empty). Nothing of an uncommitted frame is ever readable.
- error: sampled every cycle while in-frame, including the end cycle. The write pointer reverts to the commit pointer, the packer clears, and writes stop until the next start. Not in-frame: no effect.
- Overflow: if a word must be written while storage is full (FIFO_DEPTH words between the read-frame base and the write pointer), the frame is dropped as for error. Frames are never truncated.
- Read side: on a clock with data_out_enable and a committed word available, the outputs load the word and its flags, data_out_valid=1, and the read pointer advances (wraps FIFO_DEPTH-1→0).
- Empty pop: data_out and flags hold, valid=0, no pointer change.
- One-cycle pop latency. Back-to-back pops are allowed, one word per clock.
- Frame base: when a start word is popped, the read-frame base is set to its address. Storage is freed only after that frame's end word is popped (base := read pointer).
- retry: the read pointer returns to the read-frame base and the next pop returns the start word again. Ignored when no frame is partially read.
- Priority when retry and pop coincide: retry wins and no pop occurs that cycle.
- Write and read in the same cycle are independent. Full/empty are computed from registered pointers.

Test Plan:
- Push 20 bytes 01..14 (start on 01, end on 14), then pop 5 → 04030201 (s=1), 08070605, 0C0B0A09, 100F0E0D, 14131211 (e=1, count=4).
- Push 11..44 with error on 44, then 55..FF (11 bytes), then pop 4 → 88776655 (s=1), CCBBAA99, 00FFEEDD (e=1, count=3); the fourth pop gives valid=0 and data_out holds 00FFEEDD.
- Single byte A5 with start=end=1, then pop → 000000A5, s=1, e=1, count=1.
- Push a 52-byte frame (13 words > 12) → dropped, pop gives valid=0. A following 4-byte frame is stored and popped normally.
- Push the 20-byte frame, pop 2 words, assert retry, pop → 04030201 (s=1) again. The full frame then completes.
- Assert reset after 6 bytes of a frame → outputs 0, empty. A new 4-byte frame then pops correctly.
